// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encoding for the traffic sensor and controller
package traffic_pkg;

    localparam int LIGHT_W = 2;

    typedef enum logic [LIGHT_W-1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    // 2'b11 is not a legal light and must never open the departure path
    function automatic logic is_green(input logic [LIGHT_W-1:0] light);
        return light == GREEN;
    endfunction

endpackage

// File: rtl/traffic_sensor_if.sv
// rtl/traffic_sensor_if.sv - per-street detector/light in, queue status out
interface traffic_sensor_if
    import traffic_pkg::*;
#(
    parameter int QW = 4
);
    logic               car_raw;
    logic [LIGHT_W-1:0] light;
    logic [QW-1:0]      q;
    logic               t;
    logic               ovf;

    modport master (output car_raw, output light, input q, input t, input ovf);
    modport slave  (input car_raw, input light, output q, output t, output ovf);
endinterface

// File: rtl/sensor_lane.sv
// rtl/sensor_lane.sv - one street: synchronizer, debouncer, departure timer, saturating queue
module sensor_lane
    import traffic_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEB        = 3,
    parameter int DEP_PERIOD = 4
) (
    input  logic            clk,
    input  logic            rst,
    traffic_sensor_if.slave lane
);
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int TW = (DEP_PERIOD > 1) ? $clog2(DEP_PERIOD) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(DEP_PERIOD - 1);
    localparam logic [QW-1:0] Q_MAX    = '1;

    logic          r_sync1, r_sync2, r_d, r_ovf;
    logic [DW-1:0] r_deb_cnt;
    logic [TW-1:0] r_tmr;
    logic [QW-1:0] r_q;
    logic          w_green, w_arrive, w_depart;

    // Arrival fires on the same edge that d rises, so the queue moves with d
    assign w_green  = is_green(lane.light);
    assign w_arrive = r_sync2 & ~r_d & (r_deb_cnt == DEB_LAST);
    assign w_depart = w_green & (r_tmr == TMR_LAST) & (r_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= lane.car_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d       <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_d) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_d       <= r_sync2;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_tmr <= '0;
        else if (!w_green || r_tmr == TMR_LAST)
            r_tmr <= '0;
        else
            r_tmr <= r_tmr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else if (w_arrive && !w_depart) begin
            if (r_q == Q_MAX)
                r_ovf <= 1'b1;
            else
                r_q <= r_q + 1'b1;
        end else if (w_depart && !w_arrive) begin
            r_q <= r_q - 1'b1;
        end
    end

    assign lane.q   = r_q;
    assign lane.t   = (r_q != '0);
    assign lane.ovf = r_ovf;

endmodule

// File: rtl/traffic_sensor.sv
// rtl/traffic_sensor.sv - two independent street sensors feeding the light controller
module traffic_sensor
    import traffic_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEB        = 3,
    parameter int DEP_PERIOD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               car_a_raw,
    input  logic               car_b_raw,
    input  logic [LIGHT_W-1:0] la,
    input  logic [LIGHT_W-1:0] lb,
    output logic               ta,
    output logic               tb,
    output logic [QW-1:0]      qa,
    output logic [QW-1:0]      qb,
    output logic               ovf_a,
    output logic               ovf_b
);
    traffic_sensor_if #(.QW(QW)) w_lane_a ();
    traffic_sensor_if #(.QW(QW)) w_lane_b ();

    assign w_lane_a.car_raw = car_a_raw;
    assign w_lane_a.light   = la;
    assign w_lane_b.car_raw = car_b_raw;
    assign w_lane_b.light   = lb;

    sensor_lane #(.QW(QW), .DEB(DEB), .DEP_PERIOD(DEP_PERIOD)) u_lane_a (
        .clk  (clk),
        .rst  (rst),
        .lane (w_lane_a)
    );

    sensor_lane #(.QW(QW), .DEB(DEB), .DEP_PERIOD(DEP_PERIOD)) u_lane_b (
        .clk  (clk),
        .rst  (rst),
        .lane (w_lane_b)
    );

    assign ta    = w_lane_a.t;
    assign qa    = w_lane_a.q;
    assign ovf_a = w_lane_a.ovf;
    assign tb    = w_lane_b.t;
    assign qb    = w_lane_b.q;
    assign ovf_b = w_lane_b.ovf;

endmodule

// File: tb/tb_traffic_sensor.sv
// tb/tb_traffic_sensor.sv - directed bench for traffic_sensor (QW=4, DEB=3, DEP_PERIOD=4)
module tb_traffic_sensor;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       car_b_raw;
    logic [1:0] lb;
    logic       tb_t;
    logic [3:0] qb;
    logic       ovf_b;
    int         n_tests = 0;
    int         n_fail  = 0;

    traffic_sensor_if #(.QW(4)) tb_a ();

    traffic_sensor #(.QW(4), .DEB(3), .DEP_PERIOD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .car_a_raw (tb_a.car_raw),
        .car_b_raw (car_b_raw),
        .la        (tb_a.light),
        .lb        (lb),
        .ta        (tb_a.t),
        .tb        (tb_t),
        .qa        (tb_a.q),
        .qb        (qb),
        .ovf_a     (tb_a.ovf),
        .ovf_b     (ovf_b)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Five cycles high lands d on edge 5, five low lets d fall back before the next call
    task automatic arrive_a();
        tb_a.car_raw = 1'b1;
        tick(5);
        tb_a.car_raw = 1'b0;
        tick(5);
    endtask

    initial begin
        rst          = 1'b0;
        tb_a.car_raw = 1'b0;
        tb_a.light   = RED;
        car_b_raw    = 1'b0;
        lb           = RED;
        #2;
        chk("rst_qa", 32'(tb_a.q), 0);
        chk("rst_qb", 32'(qb), 0);
        chk("rst_ta", 32'(tb_a.t), 0);
        chk("rst_tb", 32'(tb_t), 0);
        chk("rst_ovf_a", 32'(tb_a.ovf), 0);
        chk("rst_ovf_b", 32'(ovf_b), 0);

        tick(1);
        rst = 1'b1;
        tick(2);

        tb_a.car_raw = 1'b1;
        tick(4);
        chk("arr_edge4_qa", 32'(tb_a.q), 0);
        tick(1);
        chk("arr_edge5_qa", 32'(tb_a.q), 1);
        chk("arr_edge5_ta", 32'(tb_a.t), 1);
        tick(5);
        tb_a.car_raw = 1'b0;
        tick(6);
        chk("arr_hold_qa", 32'(tb_a.q), 1);

        tb_a.car_raw = 1'b1;
        tick(2);
        tb_a.car_raw = 1'b0;
        tick(6);
        chk("short_pulse_qa", 32'(tb_a.q), 1);

        arrive_a();
        arrive_a();
        chk("fill3_qa", 32'(tb_a.q), 3);

        tb_a.light = GREEN;
        tick(3);
        chk("dep_edge3_qa", 32'(tb_a.q), 3);
        tick(1);
        chk("dep_edge4_qa", 32'(tb_a.q), 2);
        tick(4);
        chk("dep_edge8_qa", 32'(tb_a.q), 1);
        tick(3);
        chk("dep_edge11_ta", 32'(tb_a.t), 1);
        tick(1);
        chk("dep_edge12_qa", 32'(tb_a.q), 0);
        chk("dep_edge12_ta", 32'(tb_a.t), 0);
        chk("dep_qb_untouched", 32'(qb), 0);
        tick(4);
        chk("no_underflow_qa", 32'(tb_a.q), 0);

        tb_a.light = RED;
        for (int i = 0; i < 15; i++) arrive_a();
        chk("sat15_qa", 32'(tb_a.q), 15);
        chk("sat15_ovf", 32'(tb_a.ovf), 0);
        arrive_a();
        chk("sat16_qa", 32'(tb_a.q), 15);
        chk("sat16_ovf", 32'(tb_a.ovf), 1);
        tb_a.light = GREEN;
        tick(4);
        chk("sat_drain_qa", 32'(tb_a.q), 14);
        chk("sat_drain_ovf", 32'(tb_a.ovf), 1);

        #2;
        rst = 1'b0;
        #1;
        chk("rst1_qa", 32'(tb_a.q), 0);
        chk("rst1_ovf", 32'(tb_a.ovf), 0);
        tick(1);
        tb_a.light = RED;
        rst = 1'b1;
        tick(1);

        arrive_a();
        arrive_a();
        chk("coin_pre_qa", 32'(tb_a.q), 2);
        tb_a.car_raw = 1'b1;
        tick(1);
        tb_a.light = GREEN;
        tick(3);
        chk("coin_edge4_qa", 32'(tb_a.q), 2);
        tick(1);
        chk("coin_edge5_qa", 32'(tb_a.q), 2);
        tick(3);
        chk("coin_edge8_qa", 32'(tb_a.q), 2);
        tick(1);
        chk("coin_edge9_qa", 32'(tb_a.q), 1);
        tb_a.light   = RED;
        tb_a.car_raw = 1'b0;
        tick(5);

        for (int i = 0; i < 4; i++) arrive_a();
        chk("pre_rst_qa", 32'(tb_a.q), 5);
        tb_a.light = GREEN;
        car_b_raw  = 1'b1;
        tick(2);
        #2;
        rst = 1'b0;
        #1;
        chk("rst2_qa", 32'(tb_a.q), 0);
        chk("rst2_ta", 32'(tb_a.t), 0);
        chk("rst2_qb", 32'(qb), 0);
        tick(1);
        tb_a.light = RED;
        car_b_raw  = 1'b0;
        rst = 1'b1;
        tick(1);
        arrive_a();
        chk("resume_qa", 32'(tb_a.q), 1);
        chk("resume_ta", 32'(tb_a.t), 1);

        lb        = 2'b11;
        car_b_raw = 1'b1;
        tick(5);
        chk("b_arrive_qb", 32'(qb), 1);
        chk("b_arrive_tb", 32'(tb_t), 1);
        chk("b_qa_untouched", 32'(tb_a.q), 1);
        tick(8);
        chk("b_light3_no_dep", 32'(qb), 1);
        lb = GREEN;
        tick(4);
        chk("b_dep_qb", 32'(qb), 0);
        chk("b_ovf", 32'(ovf_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
